// File: rtl/register_read_stage_if.sv
// Register-read stage bus: decode inputs, writeback/forwarding ports,
// execute control, and the registered operand outputs.
interface register_read_stage_if;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned RIDX_W  = 4;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned ALTOP_W = 8;

  logic                dec_valid;
  logic [XLEN-1:0]     dec_pc;
  logic [XLEN-1:0]     dec_imm32;
  logic [OP_W-1:0]     dec_op;
  logic [ALTOP_W-1:0]  dec_altop;
  logic [RIDX_W-1:0]   dec_rd;
  logic [RIDX_W-1:0]   dec_rs;
  logic [RIDX_W-1:0]   dec_rt;
  logic                dec_uses_rs;
  logic                dec_uses_rt;

  logic                wb_we;
  logic [RIDX_W-1:0]   wb_reg;
  logic [XLEN-1:0]     wb_val;

  logic [RIDX_W-1:0]   exec_of_reg;
  logic [XLEN-1:0]     exec_of_val;
  logic                exec_is_load;
  logic [RIDX_W-1:0]   mem_of_reg;
  logic [XLEN-1:0]     mem_of_val;
  logic                exec_stall;
  logic                exec_flush;

  logic [XLEN-1:0]     rr_pc;
  logic [XLEN-1:0]     rr_imm32;
  logic [XLEN-1:0]     rr_rs_val;
  logic [XLEN-1:0]     rr_rt_val;
  logic [OP_W-1:0]     rr_op;
  logic [ALTOP_W-1:0]  rr_altop;
  logic [RIDX_W-1:0]   rr_rd;
  logic                rr_stall;
  logic [XLEN-1:0]     rr_bubble_cnt;

  // Upstream/environment side
  modport master (
    output dec_valid, dec_pc, dec_imm32, dec_op, dec_altop, dec_rd, dec_rs, dec_rt,
           dec_uses_rs, dec_uses_rt, wb_we, wb_reg, wb_val, exec_of_reg, exec_of_val,
           exec_is_load, mem_of_reg, mem_of_val, exec_stall, exec_flush,
    input  rr_pc, rr_imm32, rr_rs_val, rr_rt_val, rr_op, rr_altop, rr_rd, rr_stall,
           rr_bubble_cnt
  );

  // Register-read stage side
  modport slave (
    input  dec_valid, dec_pc, dec_imm32, dec_op, dec_altop, dec_rd, dec_rs, dec_rt,
           dec_uses_rs, dec_uses_rt, wb_we, wb_reg, wb_val, exec_of_reg, exec_of_val,
           exec_is_load, mem_of_reg, mem_of_val, exec_stall, exec_flush,
    output rr_pc, rr_imm32, rr_rs_val, rr_rt_val, rr_op, rr_altop, rr_rd, rr_stall,
           rr_bubble_cnt
  );
endinterface

// File: rtl/register_read_stage.sv
// Register-read pipeline stage: 16x32 register file, operand forwarding,
// load-use hazard detection, bubble insertion and bubble counting.
module register_read_stage (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  register_read_stage_if.slave  rr_if
);
  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREG   = 16;
  localparam int unsigned RIDX_W = 4;

  logic [XLEN-1:0] regfile [NREG];
  logic [XLEN-1:0] rs_val_c;
  logic [XLEN-1:0] rt_val_c;
  logic            hazard_c;
  logic            bubble_c;

  // Forwarding priority: zero register, execute, memory, writeback, file.
  function automatic logic [XLEN-1:0] select_operand(
    input logic [RIDX_W-1:0] src,
    input logic [XLEN-1:0]   rf_val,
    input logic [RIDX_W-1:0] ex_reg,
    input logic [XLEN-1:0]   ex_val,
    input logic [RIDX_W-1:0] mem_reg,
    input logic [XLEN-1:0]   mem_val,
    input logic              wb_we,
    input logic [RIDX_W-1:0] wb_reg,
    input logic [XLEN-1:0]   wb_val
  );
    logic [XLEN-1:0] val;
    if (src == '0)                     val = '0;
    else if (ex_reg == src)            val = ex_val;
    else if (mem_reg == src)           val = mem_val;
    else if (wb_we && (wb_reg == src)) val = wb_val;
    else                               val = rf_val;
    return val;
  endfunction

  // Operand selection and hazard detection for the instruction in decode
  always_comb begin
    rs_val_c = select_operand(rr_if.dec_rs, regfile[rr_if.dec_rs],
                              rr_if.exec_of_reg, rr_if.exec_of_val,
                              rr_if.mem_of_reg, rr_if.mem_of_val,
                              rr_if.wb_we, rr_if.wb_reg, rr_if.wb_val);
    rt_val_c = select_operand(rr_if.dec_rt, regfile[rr_if.dec_rt],
                              rr_if.exec_of_reg, rr_if.exec_of_val,
                              rr_if.mem_of_reg, rr_if.mem_of_val,
                              rr_if.wb_we, rr_if.wb_reg, rr_if.wb_val);
    hazard_c = rr_if.dec_valid && rr_if.exec_is_load && (rr_if.exec_of_reg != '0) &&
               ((rr_if.dec_uses_rs && (rr_if.dec_rs == rr_if.exec_of_reg)) ||
                (rr_if.dec_uses_rt && (rr_if.dec_rt == rr_if.exec_of_reg)));
    bubble_c = rr_if.exec_flush || hazard_c || !rr_if.dec_valid;
  end

  // Back-pressure to decode; a flush squashes the hazarding instruction anyway
  assign rr_if.rr_stall = rr_if.exec_stall || (hazard_c && !rr_if.exec_flush);

  // Register file write port, active regardless of stall or flush
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int unsigned i = 0; i < NREG; i++) regfile[i] <= '0;
    end else if (rr_if.wb_we && (rr_if.wb_reg != '0)) begin
      regfile[rr_if.wb_reg] <= rr_if.wb_val;
    end
  end

  // Output register: hold on stall, bubble on flush/hazard/idle, else load
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      rr_if.rr_pc         <= '0;
      rr_if.rr_imm32      <= '0;
      rr_if.rr_rs_val     <= '0;
      rr_if.rr_rt_val     <= '0;
      rr_if.rr_op         <= '0;
      rr_if.rr_altop      <= '0;
      rr_if.rr_rd         <= '0;
      rr_if.rr_bubble_cnt <= '0;
    end else if (!rr_if.exec_stall) begin
      if (bubble_c) begin
        rr_if.rr_pc     <= '0;
        rr_if.rr_imm32  <= '0;
        rr_if.rr_rs_val <= '0;
        rr_if.rr_rt_val <= '0;
        rr_if.rr_op     <= '0;
        rr_if.rr_altop  <= '0;
        rr_if.rr_rd     <= '0;
        if (rr_if.rr_bubble_cnt != '1)
          rr_if.rr_bubble_cnt <= rr_if.rr_bubble_cnt + XLEN'(1);
      end else begin
        rr_if.rr_pc     <= rr_if.dec_pc;
        rr_if.rr_imm32  <= rr_if.dec_imm32;
        rr_if.rr_rs_val <= rs_val_c;
        rr_if.rr_rt_val <= rt_val_c;
        rr_if.rr_op     <= rr_if.dec_op;
        rr_if.rr_altop  <= rr_if.dec_altop;
        rr_if.rr_rd     <= rr_if.dec_rd;
      end
    end
  end
endmodule

// File: tb/tb_register_read_stage.sv
// Scoreboard bench for register_read_stage: a stimulus process runs a
// behavioural model and queues expectations; a monitor compares the DUT.
module tb_register_read_stage;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [5:0]  op;
    logic [7:0]  altop;
    logic [3:0]  rd;
    logic [31:0] cnt;
  } out_t;

  typedef struct {
    out_t o;
    logic stall;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  logic [31:0] m_rf [16];
  out_t        m_out;
  logic        last_stall;

  register_read_stage_if bus ();

  register_read_stage dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .rr_if     (bus)
  );

  always #5 clk = ~clk;

  // Reference operand value from the architectural rules
  function automatic logic [31:0] m_operand(input logic [3:0] src);
    if (src == 4'd0) return 32'd0;
    if (bus.exec_of_reg == src) return bus.exec_of_val;
    if (bus.mem_of_reg == src) return bus.mem_of_val;
    if (bus.wb_we && bus.wb_reg == src) return bus.wb_val;
    return m_rf[src];
  endfunction

  // Apply one clock edge to the model, queue the expectation, advance time
  task automatic step();
    exp_t e;
    logic haz;
    haz = bus.dec_valid && bus.exec_is_load && (bus.exec_of_reg != 4'd0) &&
          ((bus.dec_uses_rs && bus.dec_rs == bus.exec_of_reg) ||
           (bus.dec_uses_rt && bus.dec_rt == bus.exec_of_reg));
    e.stall = bus.exec_stall || (haz && !bus.exec_flush);
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) m_rf[i] = 32'd0;
      m_out = '0;
    end else begin
      if (!bus.exec_stall) begin
        if (bus.exec_flush || haz || !bus.dec_valid) begin
          m_out.pc = 0; m_out.imm = 0; m_out.rs_val = 0; m_out.rt_val = 0;
          m_out.op = 0; m_out.altop = 0; m_out.rd = 0;
          if (m_out.cnt != 32'hFFFF_FFFF) m_out.cnt = m_out.cnt + 32'd1;
        end else begin
          m_out.pc     = bus.dec_pc;
          m_out.imm    = bus.dec_imm32;
          m_out.rs_val = m_operand(bus.dec_rs);
          m_out.rt_val = m_operand(bus.dec_rt);
          m_out.op     = bus.dec_op;
          m_out.altop  = bus.dec_altop;
          m_out.rd     = bus.dec_rd;
        end
      end
      if (bus.wb_we && bus.wb_reg != 4'd0) m_rf[bus.wb_reg] = bus.wb_val;
    end
    e.o = m_out;
    last_stall = e.stall;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus.dec_valid = 0; bus.dec_pc = 0; bus.dec_imm32 = 0; bus.dec_op = 0;
    bus.dec_altop = 0; bus.dec_rd = 0; bus.dec_rs = 0; bus.dec_rt = 0;
    bus.dec_uses_rs = 0; bus.dec_uses_rt = 0;
    bus.wb_we = 0; bus.wb_reg = 0; bus.wb_val = 0;
    bus.exec_of_reg = 0; bus.exec_of_val = 0; bus.exec_is_load = 0;
    bus.mem_of_reg = 0; bus.mem_of_val = 0;
    bus.exec_stall = 0; bus.exec_flush = 0;
  endtask

  task automatic decode(input logic [31:0] pc, input logic [3:0] rd,
                        input logic [3:0] rs, input logic [3:0] rt);
    bus.dec_valid = 1; bus.dec_pc = pc; bus.dec_imm32 = pc ^ 32'hFFFF_0000;
    bus.dec_op = 6'd1; bus.dec_altop = 8'h20; bus.dec_rd = rd;
    bus.dec_rs = rs; bus.dec_rt = rt; bus.dec_uses_rs = 1; bus.dec_uses_rt = 1;
  endtask

  // Monitor: combinational stall mid-cycle, registered outputs after the edge
  initial begin : monitor
    exp_t e;
    out_t act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        n_assert++;
        if (bus.rr_stall !== exp_q[0].stall) begin
          n_fail++;
          $display("FAIL rr_stall at %0t: got %b expected %b", $time, bus.rr_stall, exp_q[0].stall);
        end
      end
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = {bus.rr_pc, bus.rr_imm32, bus.rr_rs_val, bus.rr_rt_val,
               bus.rr_op, bus.rr_altop, bus.rr_rd, bus.rr_bubble_cnt};
        n_assert++;
        if (act !== e.o) begin
          n_fail++;
          $display("FAIL rr_outputs at %0t: got pc=%h imm=%h rs=%h rt=%h op=%h alt=%h rd=%h cnt=%h expected pc=%h imm=%h rs=%h rt=%h op=%h alt=%h rd=%h cnt=%h",
                   $time, act.pc, act.imm, act.rs_val, act.rt_val, act.op, act.altop, act.rd, act.cnt,
                   e.o.pc, e.o.imm, e.o.rs_val, e.o.rt_val, e.o.op, e.o.altop, e.o.rd, e.o.cnt);
        end
      end
    end
  end

  // Stimulus
  initial begin : stim
    m_out = '0;
    last_stall = 0;
    for (int i = 0; i < 16; i++) m_rf[i] = 32'd0;
    rst_n = 0;
    idle();
    @(posedge clk);
    #2;
    // Reset with stall, flush and a write all active: reset wins
    bus.exec_stall = 1; bus.exec_flush = 1; bus.wb_we = 1; bus.wb_reg = 4'd2; bus.wb_val = 32'hDEAD;
    step();
    idle();
    step();
    rst_n = 1;

    // Write R3 then read it with rt=0; also try writing R0
    bus.wb_we = 1; bus.wb_reg = 4'd3; bus.wb_val = 32'h1234;
    step();
    bus.wb_reg = 4'd0; bus.wb_val = 32'hFFFF;
    decode(32'h100, 4'd1, 4'd3, 4'd0);
    step();
    idle();

    // Execute forwarding beats same-cycle writeback
    decode(32'h104, 4'd2, 4'd5, 4'd0);
    bus.wb_we = 1; bus.wb_reg = 4'd5; bus.wb_val = 32'hAA;
    bus.exec_of_reg = 4'd5; bus.exec_of_val = 32'hBB;
    step();
    idle();
    // Writeback value now in the register file
    decode(32'h108, 4'd2, 4'd5, 4'd5);
    step();

    // Load-use hazard then memory forwarding
    decode(32'h10C, 4'd4, 4'd1, 4'd7);
    bus.exec_of_reg = 4'd7; bus.exec_is_load = 1; bus.exec_of_val = 32'h99;
    step();
    bus.exec_of_reg = 4'd0; bus.exec_is_load = 0;
    bus.mem_of_reg = 4'd7; bus.mem_of_val = 32'h55;
    step();
    idle();

    // Execute stall holds outputs for three edges, then the held instruction lands
    decode(32'h110, 4'd6, 4'd3, 4'd5);
    bus.exec_stall = 1;
    step(); step(); step();
    bus.exec_stall = 0;
    step();

    // Flush with valid decode; flush under stall is ignored
    decode(32'h114, 4'd6, 4'd3, 4'd3);
    bus.exec_flush = 1;
    step();
    bus.exec_stall = 1;
    step();
    bus.exec_stall = 0;
    step();
    idle();
    decode(32'h118, 4'd6, 4'd3, 4'd3);
    step();

    // Write R9, reset mid-stream, read R9 back as zero
    idle();
    bus.wb_we = 1; bus.wb_reg = 4'd9; bus.wb_val = 32'hC0FFEE;
    step();
    idle();
    decode(32'h11C, 4'd1, 4'd9, 4'd9);
    step();
    rst_n = 0;
    step();
    rst_n = 1;
    step();

    // Randomized traffic; decode holds its inputs while back-pressured
    for (int n = 0; n < 600; n++) begin
      if (!last_stall) begin
        bus.dec_valid   = ($urandom_range(0, 3) != 0);
        bus.dec_pc      = $urandom;
        bus.dec_imm32   = $urandom;
        bus.dec_op      = 6'($urandom);
        bus.dec_altop   = 8'($urandom);
        bus.dec_rd      = 4'($urandom_range(0, 7));
        bus.dec_rs      = 4'($urandom_range(0, 7));
        bus.dec_rt      = 4'($urandom_range(0, 7));
        bus.dec_uses_rs = 1'($urandom);
        bus.dec_uses_rt = 1'($urandom);
      end
      bus.wb_we        = 1'($urandom);
      bus.wb_reg       = 4'($urandom_range(0, 7));
      bus.wb_val       = $urandom;
      bus.exec_of_reg  = 4'($urandom_range(0, 7));
      bus.exec_of_val  = $urandom;
      bus.exec_is_load = ($urandom_range(0, 2) == 0);
      bus.mem_of_reg   = 4'($urandom_range(0, 7));
      bus.mem_of_val   = $urandom;
      bus.exec_stall   = ($urandom_range(0, 5) == 0);
      bus.exec_flush   = ($urandom_range(0, 7) == 0);
      rst_n            = ($urandom_range(0, 99) != 0);
      step();
    end
    rst_n = 1;
    idle();
    repeat (3) @(posedge clk);
    #3;
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
